// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial subtractor producing a - b - b_in over
// NR_BITS, one bit per clock, LSB first, through a single registered borrow.
// A start/busy/done handshake sequences it. Results are held in output
// registers until the next accepted start completes.

module serial_subtractor #(
    parameter int NR_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NR_BITS-1:0] a,
    input  logic [NR_BITS-1:0] b,
    input  logic               b_in,
    output logic [NR_BITS-1:0] diff,
    output logic               b_out,
    output logic               ovf,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = (NR_BITS > 1) ? $clog2(NR_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NR_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [NR_BITS-1:0] a_sh;
    logic [NR_BITS-1:0] a_sh_nx;
    logic [NR_BITS-1:0] b_sh;
    logic [NR_BITS-1:0] b_sh_nx;
    logic [NR_BITS-1:0] res_sh;
    logic [NR_BITS-1:0] res_sh_nx;
    logic               brw;
    logic               brw_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;

    logic [NR_BITS-1:0] diff_nx;
    logic               b_out_nx;
    logic               ovf_nx;
    logic               busy_nx;
    logic               done_nx;

    logic               bit_d;
    logic               bit_brw;
    logic [NR_BITS-1:0] res_shifted;

    // One-bit full-subtractor slice on the current LSBs and the stored borrow.
    always_comb begin
        bit_d       = a_sh[0] ^ b_sh[0] ^ brw;
        bit_brw     = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
        res_shifted = {bit_d, res_sh[NR_BITS-1:1]};
    end

    // Next-state and next-output logic; every target holds its value by default.
    // On the final bit the current brw is the borrow into the MSB, so the
    // overflow flag is that borrow XOR the borrow out of the MSB.
    always_comb begin
        state_nx  = state;
        a_sh_nx   = a_sh;
        b_sh_nx   = b_sh;
        res_sh_nx = res_sh;
        brw_nx    = brw;
        cnt_nx    = cnt;
        diff_nx   = diff;
        b_out_nx  = b_out;
        ovf_nx    = ovf;
        busy_nx   = busy;
        done_nx   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = RUN;
                    a_sh_nx   = a;
                    b_sh_nx   = b;
                    brw_nx    = b_in;
                    cnt_nx    = '0;
                    res_sh_nx = '0;
                    busy_nx   = 1'b1;
                end
            end

            RUN: begin
                a_sh_nx   = a_sh >> 1;
                b_sh_nx   = b_sh >> 1;
                res_sh_nx = res_shifted;
                brw_nx    = bit_brw;
                if (cnt == LAST_BIT) begin
                    state_nx = DONE;
                    diff_nx  = res_shifted;
                    b_out_nx = bit_brw;
                    ovf_nx   = brw ^ bit_brw;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            DONE: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end

            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            b_out  <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            a_sh   <= a_sh_nx;
            b_sh   <= b_sh_nx;
            res_sh <= res_sh_nx;
            brw    <= brw_nx;
            cnt    <= cnt_nx;
            diff   <= diff_nx;
            b_out  <= b_out_nx;
            ovf    <= ovf_nx;
            busy   <= busy_nx;
            done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive checks of the bit-serial
// subtractor handshake timing, result values, reset abort and start holding.

module tb_serial_subtractor;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         b_in;
    logic [N-1:0] diff;
    logic         b_out;
    logic         ovf;
    logic         busy;
    logic         done;

    int tests_run;
    int tests_failed;

    logic [N-1:0] last_d;
    logic         last_bo;
    logic         last_ov;

    serial_subtractor #(.NR_BITS(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to the next cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check that the registered results still hold the last completed operation.
    task automatic check_held(input string tag);
        check_output({tag, " diff held"}, 32'(diff), 32'(last_d));
        check_output({tag, " b_out held"}, 32'(b_out), 32'(last_bo));
        check_output({tag, " ovf held"}, 32'(ovf), 32'(last_ov));
    endtask

    // Full operation: start in cycle 0, busy cycles 1..5, done in cycle 5,
    // returns at cycle 6 in IDLE so the next call starts back-to-back.
    task automatic apply_stimulus(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi,
                                  input logic [N-1:0] ed, input logic eb, input logic eo,
                                  input string tag);
        a     = av;
        b     = bv;
        b_in  = bi;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        b_in  = ~bi;
        for (int c = 1; c <= N; c++) begin
            check_output({tag, " busy in run"}, 32'(busy), 32'd1);
            check_output({tag, " done early"}, 32'(done), 32'd0);
            check_held(tag);
            tick();
        end
        check_output({tag, " busy at done"}, 32'(busy), 32'd1);
        check_output({tag, " done pulse"}, 32'(done), 32'd1);
        check_output({tag, " diff"}, 32'(diff), 32'(ed));
        check_output({tag, " b_out"}, 32'(b_out), 32'(eb));
        check_output({tag, " ovf"}, 32'(ovf), 32'(eo));
        last_d  = ed;
        last_bo = eb;
        last_ov = eo;
        tick();
        check_output({tag, " busy after"}, 32'(busy), 32'd0);
        check_output({tag, " done after"}, 32'(done), 32'd0);
        check_held(tag);
    endtask

    // Reference model on integers: unsigned borrow and signed range overflow.
    task automatic model(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi,
                         output logic [N-1:0] ed, output logic eb, output logic eo);
        int ua;
        int ub;
        int sa;
        int sb;
        int ur;
        int sr;
        ua = int'(av);
        ub = int'(bv);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        ur = ua - ub - int'(bi);
        sr = sa - sb - int'(bi);
        ed = N'((ur + 16) % 16);
        eb = (ur < 0);
        eo = (sr < -8) || (sr > 7);
    endtask

    initial begin
        logic [N-1:0] md;
        logic         mb;
        logic         mo;

        tests_run    = 0;
        tests_failed = 0;
        last_d       = '0;
        last_bo      = 1'b0;
        last_ov      = 1'b0;
        rst          = 1'b1;
        start        = 1'b0;
        a            = '0;
        b            = '0;
        b_in         = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset done", 32'(done), 32'd0);
        check_held("reset");

        // Basic subtraction and latency.
        apply_stimulus(4'd5, 4'd3, 1'b0, 4'd2, 1'b0, 1'b0, "5-3");
        // Unsigned borrow cases.
        apply_stimulus(4'd3, 4'd5, 1'b0, 4'd14, 1'b1, 1'b0, "3-5");
        apply_stimulus(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, "0-0-1");
        // Signed overflow boundaries.
        apply_stimulus(4'd7, 4'd8, 1'b0, 4'd15, 1'b1, 1'b1, "7-8");
        apply_stimulus(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1, "8-1");
        apply_stimulus(4'd8, 4'd8, 1'b0, 4'd0, 1'b0, 1'b0, "8-8");

        // start held high with operands changing every cycle.
        start = 1'b1;
        a     = 4'd5;
        b     = 4'd3;
        b_in  = 1'b0;
        tick();
        for (int c = 1; c <= N; c++) begin
            a = 4'(c * 3 + 1);
            b = 4'(c * 5 + 2);
            b_in = c[0];
            check_output("hold busy", 32'(busy), 32'd1);
            check_output("hold done early", 32'(done), 32'd0);
            tick();
        end
        a = 4'd6;
        b = 4'd1;
        b_in = 1'b0;
        check_output("hold done pulse", 32'(done), 32'd1);
        check_output("hold diff", 32'(diff), 32'd2);
        check_output("hold b_out", 32'(b_out), 32'd0);
        tick();
        check_output("hold idle busy", 32'(busy), 32'd0);
        check_output("hold idle done", 32'(done), 32'd0);
        tick();
        a = 4'd0;
        b = 4'd9;
        check_output("hold reaccept busy", 32'(busy), 32'd1);
        for (int c = 8; c <= 10; c++) begin
            tick();
            check_output("hold second run done", 32'(done), 32'd0);
        end
        start = 1'b0;
        tick();
        check_output("hold second done", 32'(done), 32'd1);
        check_output("hold second diff", 32'(diff), 32'd5);
        check_output("hold second b_out", 32'(b_out), 32'd0);
        check_output("hold second ovf", 32'(ovf), 32'd0);
        tick();
        last_d  = 4'd5;
        last_bo = 1'b0;
        last_ov = 1'b0;

        // Reset in cycle 3 aborts the operation.
        a     = 4'd9;
        b     = 4'd4;
        b_in  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_output("abort busy before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("abort busy", 32'(busy), 32'd0);
        check_output("abort done", 32'(done), 32'd0);
        check_output("abort diff", 32'(diff), 32'd0);
        check_output("abort b_out", 32'(b_out), 32'd0);
        check_output("abort ovf", 32'(ovf), 32'd0);
        for (int c = 0; c < 8; c++) begin
            tick();
            check_output("abort no done", 32'(done), 32'd0);
            check_output("abort stays idle", 32'(busy), 32'd0);
        end
        last_d  = '0;
        last_bo = 1'b0;
        last_ov = 1'b0;

        // Exhaustive back-to-back sweep against the integer model.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int k = 0; k < 2; k++) begin
                    model(4'(i), 4'(j), k[0], md, mb, mo);
                    apply_stimulus(4'(i), 4'(j), k[0], md, mb, mo, "sweep");
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
